// File: rtl/cmd_scheduler_pkg.sv
// Shared engine state/command encoding and scheduler sizing defaults.
// Pure declarations; no timing or backpressure of its own.
package cmd_scheduler_pkg;

  typedef enum logic [3:0] {
    NONE   = 4'd0,
    LEFT   = 4'd1,
    RIGHT  = 4'd2,
    DOWN   = 4'd3,
    ROTATE = 4'd4,
    DROP   = 4'd5,
    HOLD   = 4'd6,
    IDLE   = 4'd7,
    WAIT   = 4'd8,
    MOVE   = 4'd9,
    OVER   = 4'd10
  } state_type;

  localparam int STATE_W     = $bits(state_type);
  localparam int SCHED_NREQ  = 4;
  localparam int SCHED_QSIZE = 8;

  function automatic logic is_urgent_cmd(input state_type c);
    return (c == DROP) || (c == HOLD);
  endfunction

endpackage

// File: rtl/cmd_scheduler_fifo.sv
// cmd_fifo: circular command buffer, registered count/full/empty; head-insert evicts tail when full.
// No internal backpressure: the caller must not push when full (head-insert may).
module cmd_fifo
  import cmd_scheduler_pkg::*;
#(
  parameter int DEPTH = SCHED_QSIZE
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     push,
  input  state_type                push_dat,
  input  logic                     ins,
  input  state_type                ins_dat,
  input  logic                     pop,
  output state_type                head_dat,
  output state_type                tail_dat,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  state_type [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]         rd_q, rd_d, wr_q, wr_d;
  logic [PW-1:0]         ins_ptr, tail_ptr;
  logic [CW-1:0]         cnt_q, cnt_d;

  assign ins_ptr  = rd_q - 1'b1;
  assign tail_ptr = wr_q - 1'b1;
  assign head_dat = mem_q[rd_q];
  assign tail_dat = mem_q[tail_ptr];
  assign count    = cnt_q;
  assign full     = (cnt_q == CW'(DEPTH));
  assign empty    = (cnt_q == '0);

  always_comb begin
    mem_d = mem_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else if (ins) begin
      // When full, rd-1 aliases the tail slot, so the insert overwrites it.
      mem_d[ins_ptr] = ins_dat;
      rd_d           = ins_ptr;
      if (full) wr_d  = tail_ptr;
      else      cnt_d = cnt_q + 1'b1;
    end else begin
      if (push) begin
        mem_d[wr_q] = push_dat;
        wr_d        = wr_q + 1'b1;
      end
      if (pop) rd_d = rd_q + 1'b1;
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_q <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cmd_scheduler.sv
// Round-robin command arbiter + FIFO; one registered issue per engine WAIT (push-to-issue 2 cycles).
// req_ready is a combinational one-hot grant; full FIFO stalls non-NONE pushes. Macro: CMD_SCHED_URGENT_EN.
module cmd_scheduler
  import cmd_scheduler_pkg::*;
#(
  parameter int              NREQ          = SCHED_NREQ,
  parameter int              QSIZE         = SCHED_QSIZE,
  parameter logic [NREQ-1:0] COALESCE_MASK = NREQ'(4'b0100)
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NREQ-1:0]                 req_valid,
  input  logic [NREQ-1:0][STATE_W-1:0]    req_cmd,
  output logic [NREQ-1:0]                 req_ready,
  input  state_type                       state,
  input  logic                            flush,
  output state_type                       cmd,
  output logic                            cmd_valid,
  output logic [$clog2(QSIZE):0]          q_count,
  output logic [15:0]                     drop_count
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(QSIZE) + 1;

`ifdef CMD_SCHED_URGENT_EN
  localparam bit URGENT = 1'b1;
`else
  localparam bit URGENT = 1'b0;
`endif

  logic [IW-1:0] rr_q, rr_d;
  logic [CW-1:0] down_q, down_d;
  logic [15:0]   drop_q, drop_d;
  logic          issued_q, issued_d;
  logic          cmd_valid_q, cmd_valid_d;
  state_type     cmd_q, cmd_d;

  logic [NREQ-1:0] coal, urg, cand;
  logic [IW-1:0]   idx, gnt_idx;
  logic            gnt_vld;
  state_type       gcmd, head_dat, tail_dat;
  logic            g_none, g_coal, g_urg;
  logic            issue, push, pop, ins, bypass, evict, drop_inc;
  logic            full, empty;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      coal[i] = COALESCE_MASK[i] && (req_cmd[i] == DOWN) && (down_q != '0);
      urg[i]  = URGENT && (i == 0) && is_urgent_cmd(state_type'(req_cmd[i]));
      cand[i] = req_valid[i] && !flush &&
                (!full || (req_cmd[i] == NONE) || coal[i] || urg[i]);
    end
  end

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IW'((int'(rr_q) + k) % NREQ);
      if (!gnt_vld && cand[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  assign req_ready = gnt_vld ? (NREQ'(1) << gnt_idx) : '0;

  always_comb begin
    gcmd   = state_type'(req_cmd[gnt_idx]);
    g_none = (gcmd == NONE);
    g_coal = coal[gnt_idx];
    g_urg  = urg[gnt_idx];
    issue  = (state == WAIT) && !issued_q && !empty && !flush;
    push   = gnt_vld && !g_none && !g_coal && !g_urg;
    // An urgent command arriving on an issue cycle goes straight out; the old head stays queued.
    bypass = gnt_vld && g_urg && issue;
    ins    = gnt_vld && g_urg && !issue;
    pop    = issue && !bypass;
    evict  = ins && full;

    cmd_valid_d = issue;
    cmd_d       = bypass ? gcmd : (pop ? head_dat : cmd_q);
    issued_d    = (state == WAIT) && (issued_q || issue);

    rr_d = rr_q;
    if (gnt_vld) rr_d = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;

    drop_inc = (gnt_vld && g_coal) || evict;
    drop_d   = (drop_inc && (drop_q != 16'hFFFF)) ? drop_q + 16'd1 : drop_q;

    if (flush) down_d = '0;
    else       down_d = down_q + CW'(push && (gcmd == DOWN))
                               - CW'(pop && (head_dat == DOWN))
                               - CW'(evict && (tail_dat == DOWN));
  end

  cmd_fifo #(.DEPTH(QSIZE)) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush    (flush),
    .push     (push),
    .push_dat (gcmd),
    .ins      (ins),
    .ins_dat  (gcmd),
    .pop      (pop),
    .head_dat (head_dat),
    .tail_dat (tail_dat),
    .count    (q_count),
    .full     (full),
    .empty    (empty)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rr_q        <= '0;
      down_q      <= '0;
      drop_q      <= '0;
      issued_q    <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_q       <= NONE;
    end else begin
      rr_q        <= rr_d;
      down_q      <= down_d;
      drop_q      <= drop_d;
      issued_q    <= issued_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_q       <= cmd_d;
    end
  end

  assign cmd        = cmd_q;
  assign cmd_valid  = cmd_valid_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_cmd_scheduler.sv
// Directed bench for cmd_scheduler: arbitration order, coalescing, full stall, one issue per WAIT, flush.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_cmd_scheduler;
  import cmd_scheduler_pkg::*;

  localparam int NREQ = 4;

  logic                         clk = 1'b0;
  logic                         reset_n;
  logic [NREQ-1:0]              req_valid;
  logic [NREQ-1:0][STATE_W-1:0] req_cmd;
  logic [NREQ-1:0]              req_ready;
  state_type                    state;
  logic                         flush;
  state_type                    cmd;
  logic                         cmd_valid;
  logic [3:0]                   q_count;
  logic [15:0]                  drop_count;

  int tests  = 0;
  int failed = 0;
  int pulses;

  cmd_scheduler dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_cmd    (req_cmd),
    .req_ready  (req_ready),
    .state      (state),
    .flush      (flush),
    .cmd        (cmd),
    .cmd_valid  (cmd_valid),
    .q_count    (q_count),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_one(input state_type exp, input string tag);
    state = WAIT;
    cyc();
    chk({tag, "_valid"}, 32'(cmd_valid), 32'd1);
    chk({tag, "_cmd"}, 32'(cmd), 32'(exp));
    state = MOVE;
    cyc();
    chk({tag, "_valid_clr"}, 32'(cmd_valid), 32'd0);
  endtask

  initial begin
    reset_n   = 1'b0;
    req_valid = '0;
    req_cmd   = '0;
    state     = IDLE;
    flush     = 1'b0;
    cyc();
    cyc();
    chk("rst_q_count", 32'(q_count), 32'd0);
    chk("rst_cmd", 32'(cmd), 32'(NONE));
    chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);

    // Single RIGHT from requester 1 while engine waits: issued two cycles later.
    reset_n      = 1'b1;
    state        = WAIT;
    req_valid    = 4'b0010;
    req_cmd[1]   = RIGHT;
    #1;
    chk("t1_ready", 32'(req_ready), 32'b0010);
    cyc();
    req_valid = '0;
    chk("t1_q_after_push", 32'(q_count), 32'd1);
    chk("t1_no_early_issue", 32'(cmd_valid), 32'd0);
    cyc();
    chk("t1_issue_valid", 32'(cmd_valid), 32'd1);
    chk("t1_issue_cmd", 32'(cmd), 32'(RIGHT));
    chk("t1_q_empty", 32'(q_count), 32'd0);
    cyc();
    chk("t1_one_pulse", 32'(cmd_valid), 32'd0);

    // Mid-operation reset, then four requesters contend: round-robin 0,1,2,3.
    reset_n = 1'b0;
    state   = MOVE;
    cyc();
    reset_n    = 1'b1;
    req_valid  = 4'b1111;
    req_cmd[0] = LEFT;
    req_cmd[1] = RIGHT;
    req_cmd[2] = DOWN;
    req_cmd[3] = ROTATE;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("t2_grant%0d", k), 32'(req_ready), 32'(1) << k);
      cyc();
      req_valid[k] = 1'b0;
    end
    chk("t2_q_count", 32'(q_count), 32'd4);
    issue_one(LEFT, "t2_ord0");
    issue_one(RIGHT, "t2_ord1");
    issue_one(DOWN, "t2_ord2");
    issue_one(ROTATE, "t2_ord3");
    chk("t2_q_drained", 32'(q_count), 32'd0);

    // Requester 2 coalesces repeated DOWNs.
    req_valid  = 4'b0100;
    req_cmd[2] = DOWN;
    #1;
    chk("t3_ready", 32'(req_ready), 32'b0100);
    cyc();
    cyc();
    cyc();
    req_valid = '0;
    chk("t3_q_coalesced", 32'(q_count), 32'd1);
    chk("t3_drop", 32'(drop_count), 32'd2);

    // Flush keeps drop_count; requester 0 DOWNs are never coalesced.
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("t3_flush_q", 32'(q_count), 32'd0);
    chk("t3_flush_drop_kept", 32'(drop_count), 32'd2);
    req_valid  = 4'b0001;
    req_cmd[0] = DOWN;
    cyc();
    cyc();
    cyc();
    req_valid = '0;
    chk("t3_req0_q", 32'(q_count), 32'd3);
    chk("t3_req0_drop", 32'(drop_count), 32'd2);

    // Fill to QSIZE with LEFTs from requester 1.
    req_valid  = 4'b0010;
    req_cmd[1] = LEFT;
    for (int k = 0; k < 5; k++) cyc();
    chk("t4_full", 32'(q_count), 32'd8);
    req_cmd[1] = RIGHT;
    #1;
    chk("t4_full_stall", 32'(req_ready), 32'd0);
    cyc();
    chk("t4_full_hold", 32'(q_count), 32'd8);
    req_valid  = 4'b0110;
    req_cmd[2] = DOWN;
    #1;
    chk("t4_full_coalesce", 32'(req_ready), 32'b0100);
    cyc();
    chk("t4_coal_drop", 32'(drop_count), 32'd3);
    req_valid  = 4'b1010;
    req_cmd[3] = NONE;
    #1;
    chk("t4_full_none", 32'(req_ready), 32'b1000);
    cyc();
    req_valid = '0;
    chk("t4_none_not_queued", 32'(q_count), 32'd8);

    // Five cycles of WAIT yield exactly one issue.
    state  = WAIT;
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      pulses += int'(cmd_valid);
    end
    chk("t4_one_pulse", 32'(pulses), 32'd1);
    chk("t4_head_cmd", 32'(cmd), 32'(DOWN));
    chk("t4_q_after", 32'(q_count), 32'd7);
    state = MOVE;
    cyc();
    issue_one(DOWN, "t5_pre0");
    issue_one(DOWN, "t5_pre1");
    chk("t5_q5", 32'(q_count), 32'd5);

    // Flush during WAIT suppresses the issue and blocks requesters.
    state      = WAIT;
    flush      = 1'b1;
    req_valid  = 4'b0010;
    req_cmd[1] = LEFT;
    #1;
    chk("t5_flush_ready", 32'(req_ready), 32'd0);
    cyc();
    flush     = 1'b0;
    req_valid = '0;
    chk("t5_flush_no_issue", 32'(cmd_valid), 32'd0);
    chk("t5_flush_q", 32'(q_count), 32'd0);
    chk("t5_flush_drop", 32'(drop_count), 32'd3);
    cyc();
    chk("t5_empty_no_issue", 32'(cmd_valid), 32'd0);

    // Flush also cleared the pending-DOWN count: next requester-2 DOWN is queued.
    state      = MOVE;
    req_valid  = 4'b0100;
    req_cmd[2] = DOWN;
    cyc();
    req_valid = '0;
    chk("t5_down_after_flush_q", 32'(q_count), 32'd1);
    chk("t5_down_after_flush_drop", 32'(drop_count), 32'd3);

`ifdef CMD_SCHED_URGENT_EN
    flush = 1'b1;
    cyc();
    flush      = 1'b0;
    req_valid  = 4'b0010;
    req_cmd[1] = LEFT;
    cyc();
    req_cmd[1] = RIGHT;
    cyc();
    req_valid  = 4'b0001;
    req_cmd[0] = DROP;
    #1;
    chk("t6_urgent_ready", 32'(req_ready), 32'b0001);
    cyc();
    req_valid = '0;
    chk("t6_q", 32'(q_count), 32'd3);
    issue_one(DROP, "t6_urgent_first");
    issue_one(LEFT, "t6_then_left");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
